// File: rtl/bb_scrambler_pkg.sv
// Shared constants and types for the baseband energy-dispersal scrambler.
// PRBS generator is 1 + x^14 + x^15 over a 15-stage register r[1:15].
package bb_scrambler_pkg;

    localparam int PRBS_LEN = 15;
    localparam logic [1:PRBS_LEN] DVB_INIT_STATE = 15'b100101010000000;
    localparam int BBFRAME_BITS = 1504;
    localparam int TAP_A = 14;
    localparam int TAP_B = 15;

    // S_SEED: seed just loaded, d_reg empty. S_DATA: d_reg holds a bit to scramble.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/bb_scrambler_if.sv
// Serial data path bundle between the framer and the scrambler.
interface bb_scrambler_if;
    import bb_scrambler_pkg::*;

    // Handshake: no back-pressure. en qualifies in_bit (first high cycle is the
    // seed-load cycle, no data); scmb_en qualifies out_bit, one bit per clock.
    logic                in_bit;
    logic                en;
    logic [1:PRBS_LEN]   initial_state;
    logic                out_bit;
    logic                scmb_en;

    modport master (
        output in_bit, en, initial_state,
        input  out_bit, scmb_en
    );

    modport slave (
        input  in_bit, en, initial_state,
        output out_bit, scmb_en
    );

endinterface

// File: rtl/bb_scrambler_lfsr.sv
// 15-stage Fibonacci LFSR, taps 14/15; prbs_bit is the feedback of the current state.
module prbs15_lfsr
    import bb_scrambler_pkg::*;
#(
    parameter int LEN = PRBS_LEN
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic [1:LEN]   seed,
    input  logic           step,
    output logic           prbs_bit
);

    logic [1:LEN] r_q;
    logic [1:LEN] r_d;

    assign prbs_bit = r_q[TAP_A] ^ r_q[TAP_B];

    // Load wins over step so a new frame never inherits a pending step.
    always_comb begin
        r_d = r_q;
        if (load) begin
            r_d = seed;
        end else if (step) begin
            r_d = {prbs_bit, r_q[1:LEN-1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/bb_scrambler.sv
// Serial scrambler top: en edge detection, input register, output register.
// Bit N captured at edge N is emitted scrambled on edge N+1.
module bb_scrambler #(
    parameter int PRBS_LEN = bb_scrambler_pkg::PRBS_LEN
) (
    input  logic                     clk,
    input  logic                     reset_n,
    bb_scrambler_if.slave            bus,
    output bb_scrambler_pkg::state_e dbg_state_o
);
    import bb_scrambler_pkg::*;

    state_e state_q;
    state_e state_d;
    logic   load;
    logic   capture;
    logic   scramble;
    logic   prbs_bit;
    logic   d_reg_q;
    logic   d_reg_d;
    logic   out_bit_q;
    logic   out_bit_d;
    logic   scmb_en_q;
    logic   scmb_en_d;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        capture  = 1'b0;
        scramble = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    load    = 1'b1;
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                if (bus.en) begin
                    capture = 1'b1;
                    state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                // The held bit is always flushed, even on the edge where en falls.
                scramble = 1'b1;
                if (bus.en) begin
                    capture = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        d_reg_d   = capture  ? bus.in_bit : d_reg_q;
        out_bit_d = scramble ? (d_reg_q ^ prbs_bit) : out_bit_q;
        scmb_en_d = scramble;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            d_reg_q   <= 1'b0;
            out_bit_q <= 1'b0;
            scmb_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_reg_q   <= d_reg_d;
            out_bit_q <= out_bit_d;
            scmb_en_q <= scmb_en_d;
        end
    end

    prbs15_lfsr #(
        .LEN (PRBS_LEN)
    ) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .seed     (bus.initial_state),
        .step     (scramble),
        .prbs_bit (prbs_bit)
    );

    assign bus.out_bit  = out_bit_q;
    assign bus.scmb_en  = scmb_en_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bb_scrambler.sv
// Scoreboard bench for bb_scrambler: driver pushes expected bits and output times,
// monitor pops and compares on every falling edge where scmb_en is high.
`timescale 1ns/1ps
module tb_bb_scrambler;
    import bb_scrambler_pkg::*;

    localparam int W = 1;

    logic   clk;
    logic   reset_n;
    state_e dbg_state;
    int     cyc;

    bb_scrambler_if bus ();

    bb_scrambler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];
    logic         got_q[$];
    logic         prbs_q[$];
    int           tests = 0;
    int           fails = 0;
    int           hi_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference PRBS as a recurrence on a bit sequence: seed occupies the 15 most
    // recent history positions (stage 1 newest), each new bit = x[n-14] ^ x[n-15].
    task automatic gen_prbs(input logic [1:15] seed, input int n);
        logic s[$];
        s = {};
        for (int j = 0; j < 15; j++) s.push_back(seed[15-j]);
        for (int m = 15; m < 15 + n; m++) s.push_back(s[m-14] ^ s[m-15]);
        prbs_q = {};
        for (int k = 1; k <= n; k++) prbs_q.push_back(s[14+k]);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n && bus.scmb_en) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_scmb_en: got scmb_en=1 at cycle %0d expected no output", cyc);
            end else begin
                logic [W-1:0] e;
                int           t;
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                if (bus.out_bit !== e[0] || cyc != t) begin
                    fails++;
                    $display("FAIL out_bit: got %0b at cycle %0d expected %0b at cycle %0d",
                             bus.out_bit, cyc, e[0], t);
                end
                got_q.push_back(bus.out_bit);
                hi_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.en  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // mode 0: zeros, 1: ones, 2: random. Expectations are pushed for bits 1..npush.
    task automatic run_frame(input logic [1:15] seed, input int nbits, input int mode,
                             input int idle, input int npush, input bit finish_en);
        logic b;
        gen_prbs(seed, nbits);
        for (int i = 0; i < idle; i++) begin
            @(posedge clk); #1;
            bus.en     = 1'b0;
            bus.in_bit = 1'($urandom);
        end
        @(posedge clk); #1;
        bus.en            = 1'b1;
        bus.initial_state = seed;
        bus.in_bit        = 1'($urandom);
        for (int k = 1; k <= nbits; k++) begin
            @(posedge clk); #1;
            b = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom);
            bus.in_bit        = b;
            bus.initial_state = 15'($urandom);
            if (k <= npush) begin
                exp_q.push_back(W'(b ^ prbs_q[k-1]));
                exp_t_q.push_back(cyc + 2);
            end
        end
        if (finish_en) begin
            @(posedge clk); #1;
            bus.en = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        zeros_cap[$];
        logic [14:0] v;
        int          bad;
        logic [1:15] seed;

        reset_n           = 1'b0;
        bus.en            = 1'b0;
        bus.in_bit        = 1'b0;
        bus.initial_state = DVB_INIT_STATE;
        repeat (3) @(negedge clk);
        check("reset_out_bit", int'(bus.out_bit), 0);
        check("reset_scmb_en", int'(bus.scmb_en), 0);
        check("reset_state_idle", int'(dbg_state == S_IDLE), 1);
        reset_n = 1'b1;

        // Raw PRBS: default seed, all-zero data
        got_q  = {};
        hi_cnt = 0;
        run_frame(DVB_INIT_STATE, BBFRAME_BITS, 0, 2, BBFRAME_BITS, 1'b1);
        drain("drain_zeros");
        check("zeros_scmb_en_cycles", hi_cnt, BBFRAME_BITS);
        zeros_cap = got_q;
        v = '0;
        for (int i = 0; i < 15 && i < zeros_cap.size(); i++) v = {v[13:0], zeros_cap[i]};
        check("first15_prbs", int'(v), int'(15'b000000111111011));
        check("first8_prbs", int'(v[14:7]), int'(8'b00000011));

        // All-ones data must complement the raw PRBS run
        got_q = {};
        run_frame(DVB_INIT_STATE, BBFRAME_BITS, 1, 2, BBFRAME_BITS, 1'b1);
        drain("drain_ones");
        bad = 0;
        for (int i = 0; i < BBFRAME_BITS; i++) begin
            if (i >= got_q.size() || i >= zeros_cap.size()) bad++;
            else if (got_q[i] !== ~zeros_cap[i]) bad++;
        end
        check("ones_complement", bad, 0);

        // en low for a single edge mid-stream: second frame restarts from seed
        run_frame(DVB_INIT_STATE, 100, 2, 2, 100, 1'b1);
        run_frame(DVB_INIT_STATE, 100, 2, 0, 100, 1'b1);
        drain("drain_en_drop");

        // Reset pulse during bit 700
        run_frame(DVB_INIT_STATE, 700, 2, 2, 699, 1'b0);
        @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b0;
        bus.en  = 1'b0;
        #1;
        check("async_reset_out_bit", int'(bus.out_bit), 0);
        check("async_reset_scmb_en", int'(bus.scmb_en), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("reset_abandon_queue", exp_q.size(), 0);
        run_frame(DVB_INIT_STATE, 200, 2, 1, 200, 1'b1);
        drain("drain_after_reset");

        // All-zero seed: output equals input
        run_frame(15'b0, 300, 2, 2, 300, 1'b1);
        drain("drain_zero_seed");

        // Back-to-back random packets, each preceded by reset and 2-3 idle cycles
        for (int p = 0; p < 50; p++) begin
            do_reset();
            seed = (p % 2 == 0) ? DVB_INIT_STATE : 15'($urandom);
            run_frame(seed, BBFRAME_BITS, 2, $urandom_range(2, 3), BBFRAME_BITS, 1'b1);
            drain("drain_packet");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
